// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the instruction register / control FSM.
//   state_e          : control FSM states
//   OPC_* / OP_*     : opcode and op field encodings of the supported instructions
//   VSEL_* / ALU_*   : writeback-source and ALU operation encodings seen by the datapath
//   *_MSB / *_LSB    : instruction field bit positions
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;
    localparam int IMM8_MSB = 7;
    localparam int IMM5_MSB = 4;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: purely combinational field split of the instruction register.
//   ir               in  16  instruction word
//   opcode, op       out     major / minor opcode
//   rn, rd, rm, sh   out     register selects and shift control
//   sximm8, sximm5   out 16  sign-extended IR[7:0] and IR[4:0]
//   illegal          out     word is not one of the supported instructions
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        illegal
);

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign op     = ir[OP_MSB:OP_LSB];
    assign rn     = ir[RN_MSB:RN_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign sh     = ir[SH_MSB:SH_LSB];
    assign rm     = ir[RM_MSB:RM_LSB];

    assign sximm8 = {{8{ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};
    assign sximm5 = {{11{ir[IMM5_MSB]}}, ir[IMM5_MSB:0]};

    // Every op of the ALU opcode is legal; the MOV opcode only has imm and reg forms.
    always_comb begin
        illegal = 1'b1;
        if (opcode == OPC_ALU) begin
            illegal = 1'b0;
        end else if (opcode == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG)) begin
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register plus multi-cycle control FSM for the 16-bit
// register/ALU datapath.
//   clk, reset_n                       clock, async active-low reset
//   in, load                           instruction word and IR capture (WAIT only)
//   s, w                               start request / idle-ready
//   illegal                            pulses in DECODE for an unsupported word
//   readnum, writenum, write, vsel     register-file control
//   loada, loadb, loadc, loads         datapath register enables
//   asel, bsel, shift, ALUop           operand muxes, shifter, ALU operation
//   sximm8, sximm5                     sign-extended immediates
//   state_dbg                          current FSM state
//
// Handshake: w is "ready" and s is "valid". A start is accepted on any rising
// edge where both are high; w then stays low until the instruction completes.
// s is ignored while w is low, and if s is still high when w returns, the
// next instruction starts on the following edge.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [2:0]  state_dbg
);

    state_e      state;
    state_e      state_next;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       dec_illegal;

    instr_dec u_dec (
        .ir      (ir),
        .opcode  (opcode),
        .op      (op),
        .rn      (rn),
        .rd      (rd),
        .rm      (rm),
        .sh      (sh),
        .sximm8  (sximm8),
        .sximm5  (sximm5),
        .illegal (dec_illegal)
    );

    logic is_mov_imm, is_mov_reg, is_mvn, is_cmp;
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

    // IR only captures in WAIT so the word is frozen while it executes. A load
    // on the same edge that accepts s is therefore the word DECODE sees.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if (state == S_WAIT && load) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    assign state_dbg = state;
    assign shift     = sh;

    always_comb begin
        state_next = state;
        w          = 1'b0;
        illegal    = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = VSEL_C;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        ALUop      = ALU_ADD;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal    = 1'b1;
                    state_next = S_WAIT;
                end else if (is_mov_imm) begin
                    state_next = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    // Single-operand forms never need the A operand.
                    state_next = S_GET_B;
                end else begin
                    state_next = S_GET_A;
                end
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_ALU;
            end
            S_ALU: begin
                loadc = 1'b1;
                // asel zeroes the A operand so MOV reg computes 0 + B.
                asel  = is_mov_reg || is_mvn;
                ALUop = is_mov_reg ? ALU_ADD : op;
                loads = is_cmp;
                state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

endmodule
